percept_seq: RTL and testbench

UART-command sequencer for the perceptron datapath. It sits between the `uart` and `percept` instances in the FPGA top level. It decodes command bytes from the UART receiver and drives the `percept` strobes: `shift_in`, `mul_and_acc` and `shift_out`. It returns results and acknowledgements through the UART transmitter, so the whole perceptron can be driven from a host serial link.

---
 rtl/percept_seq_if.sv | 23 ++
 rtl/percept_seq.sv | 182 ++++++++++++++++++
 tb/tb_percept_seq.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/percept_seq_if.sv
// rtl/percept_seq_if.sv - UART and perceptron strobe bundle seen by the command sequencer
interface percept_seq_if;
    logic        recieved;
    logic [7:0]  data_rx;
    logic        busy_tx;
    logic        transmit;
    logic [7:0]  data_tx;
    logic        shift_in;
    logic [7:0]  data_in;
    logic        mul_and_acc;
    logic        shift_out;
    logic [15:0] data_out;

    modport master (
        input  recieved, data_rx, busy_tx, data_out,
        output transmit, data_tx, shift_in, data_in, mul_and_acc, shift_out
    );

    modport slave (
        output recieved, data_rx, busy_tx, data_out,
        input  transmit, data_tx, shift_in, data_in, mul_and_acc, shift_out
    );
endinterface

// File: rtl/percept_seq.sv
// rtl/percept_seq.sv - UART command decoder driving the perceptron strobes and replies
module percept_seq #(
    parameter int MAC_CYCLES = 4,
    parameter int TIMEOUT    = 50000
) (
    input  logic          clk,
    input  logic          rst,
    percept_seq_if.master bus,
    output logic          busy,
    output logic          overrun
);
    typedef enum logic [3:0] {
        IDLE, ARG, SHIFT, MAC, MWAIT, READ, CAP, TXHI, TXLO, TXACK, TXW
    } state_t;

    localparam logic [7:0] CMD_SHIFT = 8'h10;
    localparam logic [7:0] CMD_MAC   = 8'h20;
    localparam logic [7:0] CMD_READ  = 8'h30;
    localparam logic [7:0] ACK_OK    = 8'hAA;
    localparam logic [7:0] ACK_ERR   = 8'hEE;

    state_t      state_q, state_d;
    state_t      ret_q, ret_d;
    logic [19:0] tmo_q, tmo_d;
    logic [7:0]  wait_q, wait_d;
    logic [15:0] result_q, result_d;
    logic [7:0]  ack_q, ack_d;
    logic [7:0]  data_in_q, data_in_d;
    logic [7:0]  data_tx_q, data_tx_d;
    logic        transmit_q, transmit_d;
    logic        shift_in_q, shift_in_d;
    logic        mac_q, mac_d;
    logic        shift_out_q, shift_out_d;
    logic        busy_q, busy_d;
    logic        overrun_q, overrun_d;
    logic        txw_first_q, txw_first_d;

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        tmo_d       = tmo_q;
        wait_d      = wait_q;
        result_d    = result_q;
        ack_d       = ack_q;
        data_in_d   = data_in_q;
        data_tx_d   = data_tx_q;
        transmit_d  = 1'b0;
        shift_in_d  = 1'b0;
        mac_d       = 1'b0;
        shift_out_d = 1'b0;
        overrun_d   = overrun_q;
        txw_first_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.recieved) begin
                    case (bus.data_rx)
                        CMD_SHIFT: begin
                            state_d = ARG;
                            tmo_d   = 20'd0;
                        end
                        CMD_MAC: begin
                            state_d = MAC;
                            mac_d   = 1'b1;
                        end
                        CMD_READ: begin
                            state_d     = READ;
                            shift_out_d = 1'b1;
                        end
                        default: begin
                            state_d = TXACK;
                            ack_d   = ACK_ERR;
                        end
                    endcase
                end
            end
            ARG: begin
                tmo_d = tmo_q + 20'd1;
                // A byte arriving in the very cycle the timeout expires still wins.
                if (bus.recieved) begin
                    state_d    = SHIFT;
                    data_in_d  = bus.data_rx;
                    shift_in_d = 1'b1;
                end else if (tmo_q == 20'(TIMEOUT)) begin
                    state_d = TXACK;
                    ack_d   = ACK_ERR;
                end
            end
            SHIFT: state_d = IDLE;
            MAC: begin
                state_d = MWAIT;
                wait_d  = 8'(MAC_CYCLES);
            end
            MWAIT: begin
                wait_d = wait_q - 8'd1;
                if (wait_q <= 8'd1) begin
                    state_d = TXACK;
                    ack_d   = ACK_OK;
                end
            end
            READ: state_d = CAP;
            CAP: begin
                state_d  = TXHI;
                result_d = bus.data_out;
            end
            TXHI, TXLO, TXACK: begin
                if (transmit_q) begin
                    state_d     = TXW;
                    txw_first_d = 1'b1;
                    ret_d       = (state_q == TXHI) ? TXLO : IDLE;
                end
            end
            TXW: begin
                if (!txw_first_q && !bus.busy_tx) begin
                    state_d = ret_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // Launch is registered, so it is decided on the edge into (or while in) a transmit state.
        if ((state_d == TXHI || state_d == TXLO || state_d == TXACK) && !bus.busy_tx) begin
            transmit_d = 1'b1;
            case (state_d)
                TXHI:    data_tx_d = result_d[15:8];
                TXLO:    data_tx_d = result_d[7:0];
                default: data_tx_d = ack_d;
            endcase
        end

        if (bus.recieved && state_q != IDLE && state_q != ARG) begin
            overrun_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ret_q       <= IDLE;
            tmo_q       <= 20'd0;
            wait_q      <= 8'd0;
            result_q    <= 16'h0000;
            ack_q       <= 8'h00;
            data_in_q   <= 8'h00;
            data_tx_q   <= 8'h00;
            transmit_q  <= 1'b0;
            shift_in_q  <= 1'b0;
            mac_q       <= 1'b0;
            shift_out_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            txw_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            tmo_q       <= tmo_d;
            wait_q      <= wait_d;
            result_q    <= result_d;
            ack_q       <= ack_d;
            data_in_q   <= data_in_d;
            data_tx_q   <= data_tx_d;
            transmit_q  <= transmit_d;
            shift_in_q  <= shift_in_d;
            mac_q       <= mac_d;
            shift_out_q <= shift_out_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            txw_first_q <= txw_first_d;
        end
    end

    assign bus.transmit    = transmit_q;
    assign bus.data_tx     = data_tx_q;
    assign bus.shift_in    = shift_in_q;
    assign bus.data_in     = data_in_q;
    assign bus.mul_and_acc = mac_q;
    assign bus.shift_out   = shift_out_q;
    assign busy            = busy_q;
    assign overrun         = overrun_q;
endmodule

// File: tb/tb_percept_seq.sv
// tb/tb_percept_seq.sv - directed bench for the UART command sequencer
module tb_percept_seq;
    logic clk;
    logic rst;
    logic busy;
    logic overrun;

    percept_seq_if bus ();

    percept_seq #(
        .MAC_CYCLES(4),
        .TIMEOUT   (16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .busy   (busy),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    int tx_cnt;
    int shift_cnt;
    int mac_cnt;
    int so_cnt;
    int overlap_cnt;

    always @(posedge clk) begin
        if (!rst) begin
            if (bus.transmit)    tx_cnt    <= tx_cnt + 1;
            if (bus.shift_in)    shift_cnt <= shift_cnt + 1;
            if (bus.mul_and_acc) mac_cnt   <= mac_cnt + 1;
            if (bus.shift_out)   so_cnt    <= so_cnt + 1;
            if (32'(bus.transmit) + 32'(bus.shift_in) + 32'(bus.mul_and_acc) + 32'(bus.shift_out) > 32'd1)
                overlap_cnt <= overlap_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.recieved = 1'b1;
        bus.data_rx  = b;
        @(negedge clk);
        bus.recieved = 1'b0;
    endtask

    task automatic wait_tx(output int n);
        n = 0;
        while (!bus.transmit && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_transmit"}, 32'(bus.transmit), 32'd0);
        check({tag, "_shift_in"}, 32'(bus.shift_in), 32'd0);
        check({tag, "_mac"},      32'(bus.mul_and_acc), 32'd0);
        check({tag, "_shift_out"},32'(bus.shift_out), 32'd0);
        check({tag, "_busy"},     32'(busy), 32'd0);
        check({tag, "_overrun"},  32'(overrun), 32'd0);
        check({tag, "_data_in"},  32'(bus.data_in), 32'h00);
        check({tag, "_data_tx"},  32'(bus.data_tx), 32'h00);
    endtask

    initial begin
        int n;
        int base;
        checks       = 0;
        errors       = 0;
        tx_cnt       = 0;
        shift_cnt    = 0;
        mac_cnt      = 0;
        so_cnt       = 0;
        overlap_cnt  = 0;
        rst          = 1'b1;
        bus.recieved = 1'b0;
        bus.data_rx  = 8'h00;
        bus.busy_tx  = 1'b0;
        bus.data_out = 16'h0000;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // SHIFT with argument
        send_byte(8'h10);
        check("arg_busy", 32'(busy), 32'd1);
        send_byte(8'h5A);
        check("shift_pulse", 32'(bus.shift_in), 32'd1);
        check("shift_data", 32'(bus.data_in), 32'h5A);
        @(negedge clk);
        check("shift_one_wide", 32'(bus.shift_in), 32'd0);
        check("shift_busy_low", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("shift_count", 32'(shift_cnt), 32'd1);
        check("shift_no_reply", 32'(tx_cnt), 32'd0);

        // MAC: reply lands MAC_CYCLES+1 cycles after the strobe
        send_byte(8'h20);
        check("mac_pulse", 32'(bus.mul_and_acc), 32'd1);
        wait_tx(n);
        check("mac_latency", 32'(n), 32'd5);
        check("mac_ack", 32'(bus.data_tx), 32'hAA);
        wait_idle("mac_idle");
        check("mac_count", 32'(mac_cnt), 32'd1);

        // READ with the low byte held off by a busy transmitter
        bus.data_out = 16'hBEEF;
        send_byte(8'h30);
        check("read_pulse", 32'(bus.shift_out), 32'd1);
        bus.data_out = 16'h0000;
        @(negedge clk);
        bus.data_out = 16'hBEEF;
        wait_tx(n);
        check("read_hi_latency", 32'(n), 32'd1);
        check("read_hi_byte", 32'(bus.data_tx), 32'hBE);
        bus.busy_tx = 1'b1;
        base = tx_cnt;
        repeat (100) @(negedge clk);
        check("read_held_by_busy", 32'(tx_cnt - base), 32'd1);
        check("read_data_tx_stable", 32'(bus.data_tx), 32'hBE);
        bus.busy_tx = 1'b0;
        wait_tx(n);
        check("read_lo_after_busy", 32'(n >= 1 && n <= 3), 32'd1);
        check("read_lo_byte", 32'(bus.data_tx), 32'hEF);
        wait_idle("read_idle");

        // Unknown command
        send_byte(8'h7F);
        check("bad_cmd_tx", 32'(bus.transmit), 32'd1);
        check("bad_cmd_ack", 32'(bus.data_tx), 32'hEE);
        wait_idle("bad_cmd_idle");

        // ARG timeout: 17 cycles in ARG then the error reply
        base = shift_cnt;
        send_byte(8'h10);
        wait_tx(n);
        check("tmo_latency", 32'(n), 32'd17);
        check("tmo_ack", 32'(bus.data_tx), 32'hEE);
        wait_idle("tmo_idle");
        check("tmo_no_shift", 32'(shift_cnt - base), 32'd0);

        // Argument arriving on the last cycle before timeout is still taken
        send_byte(8'h10);
        repeat (15) @(negedge clk);
        send_byte(8'h33);
        check("tmo_edge_shift", 32'(bus.shift_in), 32'd1);
        check("tmo_edge_data", 32'(bus.data_in), 32'h33);
        wait_idle("tmo_edge_idle");

        // Overrun during MWAIT
        check("overrun_clear", 32'(overrun), 32'd0);
        base = so_cnt;
        send_byte(8'h20);
        send_byte(8'h30);
        check("overrun_set", 32'(overrun), 32'd1);
        wait_tx(n);
        check("overrun_mac_latency", 32'(n), 32'd3);
        check("overrun_mac_ack", 32'(bus.data_tx), 32'hAA);
        wait_idle("overrun_idle");
        check("overrun_sticky", 32'(overrun), 32'd1);
        check("overrun_dropped", 32'(so_cnt - base), 32'd0);

        // Reset between high and low byte
        bus.data_out = 16'h1234;
        send_byte(8'h30);
        wait_tx(n);
        check("rst_hi_byte", 32'(bus.data_tx), 32'h12);
        bus.busy_tx = 1'b1;
        repeat (5) @(negedge clk);
        base = tx_cnt;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        bus.busy_tx = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_no_lo_byte", 32'(tx_cnt - base), 32'd0);
        send_byte(8'h20);
        check("rst_mac_pulse", 32'(bus.mul_and_acc), 32'd1);
        wait_tx(n);
        check("rst_mac_latency", 32'(n), 32'd5);
        check("rst_mac_ack", 32'(bus.data_tx), 32'hAA);
        wait_idle("rst_mac_idle");

        check("no_strobe_overlap", 32'(overlap_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
